// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter for the IF and MEM pipeline ports; MEM has fixed priority.
// Define MEM_ARB_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES without bus_ack_i.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        timeout_err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_REQ  = 2'd1,
        MEM_REQ = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] if_buf_q, if_buf_d;
    logic [31:0] mem_buf_q, mem_buf_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        err_q, err_d;
    logic        timeout_s;
    logic        advance_s;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_s = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 32'd1));

    // Wait-cycle counter: held at zero in IDLE so every REQ state starts from zero.
    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Wait-cycle counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg_s;

    assign timeout_s    = 1'b0;
    assign unused_cfg_s = (TIMEOUT_CYCLES > CNT_W);
`endif

    // A port holds the pipeline until its own access has completed.
    assign if_stallreq_o  = if_ce_i & ~if_done_q;
    assign mem_stallreq_o = mem_ce_i & ~mem_done_q;
    assign advance_s      = ~if_stallreq_o & ~mem_stallreq_o & ~stall_i;

    // Next-state, bus latch and done/buffer update logic.
    always_comb begin
        state_d     = state_q;
        if_done_d   = advance_s ? 1'b0 : if_done_q;
        mem_done_d  = advance_s ? 1'b0 : mem_done_q;
        if_buf_d    = if_buf_q;
        mem_buf_d   = mem_buf_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (mem_stallreq_o) begin
                    state_d     = MEM_REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_sel_d   = mem_sel_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                end else if (if_stallreq_o) begin
                    state_d     = IF_REQ;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'hF;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = 32'h0000_0000;
                end else begin
                    state_d     = IDLE;
                end
            end
            IF_REQ, MEM_REQ: begin
                if (bus_ack_i) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (state_q == IF_REQ) begin
                        if_done_d = 1'b1;
                        if_buf_d  = bus_rdata_i;
                    end else begin
                        mem_done_d = 1'b1;
                        mem_buf_d  = bus_we_q ? mem_buf_q : bus_rdata_i;
                    end
                end else if (timeout_s) begin
                    // Aborted access completes with zero data so the pipeline can move on.
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == IF_REQ) begin
                        if_done_d = 1'b1;
                        if_buf_d  = 32'h0000_0000;
                    end else begin
                        mem_done_d = 1'b1;
                        mem_buf_d  = 32'h0000_0000;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State, done flags, read buffers and bus drive registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_buf_q    <= 32'h0000_0000;
            mem_buf_q   <= 32'h0000_0000;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_buf_q    <= if_buf_d;
            mem_buf_q   <= mem_buf_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            err_q       <= err_d;
        end
    end

    assign if_data_o     = if_buf_q;
    assign mem_rdata_o   = mem_buf_q;
    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_sel_o     = bus_sel_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every cycle, directed scenarios
// with literal expectations, and a bus responder with programmable wait states.
module tb_mem_bus_arbiter;

    localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int W3    = 4;
`else
    localparam bit TO_EN = 1'b0;
    localparam int W3    = 5;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        if_ce_i = 1'b0;
    logic [31:0] if_addr_i = 32'd0;
    logic [31:0] if_data_o;
    logic        if_stallreq_o;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_sel_i = 4'h0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] mem_wdata_i = 32'd0;
    logic [31:0] mem_rdata_o;
    logic        mem_stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = 32'd0;
    logic        bus_ack_i = 1'b0;
    logic        timeout_err_o;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
        .if_stallreq_o(if_stallreq_o),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .mem_stallreq_o(mem_stallreq_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory contents seen by the responder.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h3C01_0001;
        return a * 32'd3 + 32'h0000_1111;
    endfunction

    // Bus responder: acks after req_cycles cycles of bus_req_o, logs every acked transfer.
    int          req_cycles = 1;
    bit          ack_en = 1'b1;
    bit          spurious = 1'b0;
    int          wcnt = 0;
    int          ack_n = 0;
    logic [31:0] log_addr [0:15];
    logic        log_we   [0:15];

    always @(posedge clk) begin
        #1;
        if (bus_req_o && ack_en && (wcnt >= req_cycles - 1)) begin
            bus_ack_i   = 1'b1;
            bus_rdata_i = mem_word(bus_addr_o);
            if (ack_n < 16) begin
                log_addr[ack_n] = bus_addr_o;
                log_we[ack_n]   = bus_we_o;
            end
            ack_n++;
            wcnt = 0;
        end else begin
            bus_ack_i   = spurious;
            bus_rdata_i = 32'hDEAD_BEEF;
            wcnt        = bus_req_o ? wcnt + 1 : 0;
        end
    end

    // Transaction-level model: one outstanding transfer, per-port completion and data.
    bit          m_act = 1'b0, m_is_mem = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;
    logic [3:0]  m_sel = 4'h0;
    int          m_waited = 0;
    bit          m_if_done = 1'b0, m_mem_done = 1'b0, m_err = 1'b0;
    logic [31:0] m_if_buf = 32'd0, m_mem_buf = 32'd0;

    always @(posedge clk or negedge rst) begin : model
        bit adv, nif, nmem;
        if (!rst) begin
            m_act <= 1'b0; m_if_done <= 1'b0; m_mem_done <= 1'b0;
            m_if_buf <= 32'd0; m_mem_buf <= 32'd0; m_err <= 1'b0;
        end else begin
            adv  = !(if_ce_i && !m_if_done) && !(mem_ce_i && !m_mem_done) && !stall_i;
            nif  = adv ? 1'b0 : m_if_done;
            nmem = adv ? 1'b0 : m_mem_done;
            if (m_act) begin
                if (bus_ack_i) begin
                    m_act <= 1'b0;
                    if (m_is_mem) begin
                        nmem = 1'b1;
                        if (!m_we) m_mem_buf <= bus_rdata_i;
                    end else begin
                        nif = 1'b1;
                        m_if_buf <= bus_rdata_i;
                    end
                end else if (TO_EN && (m_waited + 1 == TO)) begin
                    m_act <= 1'b0;
                    m_err <= 1'b1;
                    if (m_is_mem) begin nmem = 1'b1; m_mem_buf <= 32'd0; end
                    else begin nif = 1'b1; m_if_buf <= 32'd0; end
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else if (mem_ce_i && !m_mem_done) begin
                m_act <= 1'b1; m_is_mem <= 1'b1; m_we <= mem_we_i; m_sel <= mem_sel_i;
                m_addr <= mem_addr_i; m_wdata <= mem_wdata_i; m_waited <= 0;
            end else if (if_ce_i && !m_if_done) begin
                m_act <= 1'b1; m_is_mem <= 1'b0; m_we <= 1'b0; m_sel <= 4'hF;
                m_addr <= if_addr_i; m_wdata <= 32'd0; m_waited <= 0;
            end
            m_if_done  <= nif;
            m_mem_done <= nmem;
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk1("if_stallreq", if_stallreq_o, if_ce_i & ~m_if_done);
            chk1("mem_stallreq", mem_stallreq_o, mem_ce_i & ~m_mem_done);
            chk1("bus_req", bus_req_o, m_act);
            if (m_act) begin
                chk("bus_addr", bus_addr_o, m_addr);
                chk1("bus_we", bus_we_o, m_we);
                chk("bus_sel", {28'd0, bus_sel_o}, {28'd0, m_sel});
                if (m_we) chk("bus_wdata", bus_wdata_o, m_wdata);
            end
            chk("if_data", if_data_o, m_if_buf);
            chk("mem_rdata", mem_rdata_o, m_mem_buf);
            chk1("timeout_err", timeout_err_o, m_err);
        end
    end

    task automatic run_until_free(input int maxc, output int nstall);
        bit fr = 1'b0;
        nstall = 0;
        for (int c = 0; c < maxc && !fr; c++) begin
            @(negedge clk);
            if (!if_stallreq_o && !mem_stallreq_o) fr = 1'b1;
            else nstall++;
        end
        chk1("free_in_time", fr, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nst, a0, nreq;
        bit seen;
        repeat (2) @(negedge clk);
        chk1("rst_bus_req", bus_req_o, 1'b0);
        chk1("rst_bus_we", bus_we_o, 1'b0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_mem_rdata", mem_rdata_o, 32'd0);
        chk1("rst_timeout", timeout_err_o, 1'b0);
        rst = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // 1: IF-only fetch, single-cycle ack
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0100;
        run_until_free(10, nst);
        chk("t1_stall_cycles", nst, 32'd2);
        chk("t1_if_data", if_data_o, 32'h3C01_0001);
        if_ce_i = 1'b0;

        // 2: MEM write and IF fetch pending together
        a0 = ack_n;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF;
        mem_addr_i = 32'h0000_0200; mem_wdata_i = 32'h55AA_55AA;
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0104;
        run_until_free(12, nst);
        chk("t2_stall_cycles", nst, 32'd4);
        chk("t2_first_addr", log_addr[a0], 32'h0000_0200);
        chk1("t2_first_we", log_we[a0], 1'b1);
        chk("t2_second_addr", log_addr[a0 + 1], 32'h0000_0104);
        chk1("t2_second_we", log_we[a0 + 1], 1'b0);
        chk("t2_if_data", if_data_o, 32'h0000_141D);
        chk("t2_mem_unchanged", mem_rdata_o, 32'd0);
        // next instruction pair: one advance must have cleared both done flags
        mem_we_i = 1'b0; mem_addr_i = 32'h0000_0300; if_addr_i = 32'h0000_0108;
        @(negedge clk);
        chk1("t2_if_restall", if_stallreq_o, 1'b1);
        chk1("t2_mem_restall", mem_stallreq_o, 1'b1);
        run_until_free(12, nst);
        chk("t2b_mem_rdata", mem_rdata_o, 32'h0000_1A11);
        chk("t2b_if_data", if_data_o, 32'h0000_1429);
        if_ce_i = 1'b0; mem_ce_i = 1'b0;

        // 3: wait states, requester address changes mid-transfer
        req_cycles = W3;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0400;
        nreq = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus_req_o) begin
                nreq++;
                chk("t3_addr_stable", bus_addr_o, 32'h0000_0400);
            end
            if (!mem_stallreq_o) seen = 1'b1;
            if (c == 2) mem_addr_i = 32'h0000_0404;
        end
        chk1("t3_completed", seen, 1'b1);
        chk("t3_req_cycles", nreq, W3);
        chk("t3_mem_rdata", mem_rdata_o, 32'h0000_1D11);
        @(posedge clk); #1;
        mem_ce_i = 1'b0; req_cycles = 1;

        // 4: external stall after done, spurious acks while idle
        a0 = ack_n;
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0104; stall_i = 1'b1; spurious = 1'b1;
        nreq = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus_req_o) nreq++;
        end
        chk("t4_req_cycles", nreq, 32'd1);
        chk("t4_ack_count", ack_n - a0, 32'd1);
        chk1("t4_if_stall", if_stallreq_o, 1'b0);
        chk("t4_if_data", if_data_o, 32'h0000_141D);
        @(posedge clk); #1;
        stall_i = 1'b0; spurious = 1'b0;
        @(posedge clk); #1;
        if_ce_i = 1'b0;

        // 5: reset in the middle of a MEM transfer
        req_cycles = 10;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0500;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (bus_req_o) seen = 1'b1;
        end
        chk1("t5_req_seen", seen, 1'b1);
        #2;
        rst = 1'b0; mem_ce_i = 1'b0;
        #1;
        chk1("t5_req_drop", bus_req_o, 1'b0);
        chk("t5_bus_addr", bus_addr_o, 32'd0);
        chk("t5_if_data", if_data_o, 32'd0);
        chk("t5_mem_rdata", mem_rdata_o, 32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk1("t5_idle_after", bus_req_o, 1'b0);
        @(posedge clk); #1;
        req_cycles = 1;
        if_ce_i = 1'b1; if_addr_i = 32'h0000_0100;
        run_until_free(10, nst);
        chk("t5_refetch_stall", nst, 32'd2);
        chk("t5_refetch_data", if_data_o, 32'h3C01_0001);
        if_ce_i = 1'b0;

        // 6: no ack at all
        ack_en = 1'b0;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0600;
`ifdef MEM_ARB_TIMEOUT_EN
        nreq = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus_req_o) nreq++;
            if (!mem_stallreq_o) seen = 1'b1;
        end
        chk1("t6_aborted", seen, 1'b1);
        chk("t6_req_cycles", nreq, 32'd4);
        chk("t6_mem_rdata", mem_rdata_o, 32'd0);
        chk1("t6_timeout", timeout_err_o, 1'b1);
        @(posedge clk); #1;
        mem_ce_i = 1'b0;
        repeat (3) @(negedge clk);
        chk1("t6_timeout_sticky", timeout_err_o, 1'b1);
`else
        nreq = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus_req_o) nreq++;
        end
        chk("t6_req_cycles", nreq, 32'd11);
        chk1("t6_still_stalled", mem_stallreq_o, 1'b1);
        chk1("t6_no_timeout", timeout_err_o, 1'b0);
        ack_en = 1'b1;
        run_until_free(10, nst);
        chk("t6_mem_rdata", mem_rdata_o, 32'h0000_2311);
        mem_ce_i = 1'b0;
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
